// File: rtl/fpu_cmd_seq_pkg.sv
// Shared types and constants for the FPU command sequencer:
// FSM states, response flag layout and FPU opcode values.
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    RUN  = 2'b10,
    RESP = 2'b11
  } seq_state_t;

  localparam int FLAGS_W     = 7;
  localparam int FLG_TIMEOUT = 6;
  localparam int FLG_INV     = 5;
  localparam int FLG_OV      = 4;
  localparam int FLG_UN      = 3;
  localparam int FLG_EQ      = 2;
  localparam int FLG_GREAT   = 1;
  localparam int FLG_LESS    = 0;

  localparam logic [FLAGS_W-1:0] FLAGS_TIMEOUT = 7'b1000000;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;

  // Assemble the response flag word in its documented bit order.
  function automatic logic [FLAGS_W-1:0] pack_flags(
    input logic timeout,
    input logic inv,
    input logic ov,
    input logic un,
    input logic eq,
    input logic great,
    input logic less
  );
    logic [FLAGS_W-1:0] f;
    f              = '0;
    f[FLG_TIMEOUT] = timeout;
    f[FLG_INV]     = inv;
    f[FLG_OV]      = ov;
    f[FLG_UN]      = un;
    f[FLG_EQ]      = eq;
    f[FLG_GREAT]   = great;
    f[FLG_LESS]    = less;
    return f;
  endfunction

endpackage

// File: rtl/fpu_cmd_seq_if.sv
// Bundle of command, FPU-side and response signals around the sequencer.
// slave = sequencer view, master = surrounding source/FPU/sink view.
interface fpu_cmd_seq_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_in1;
  logic [WIDTH-1:0] cmd_in2;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_rm;

  logic [WIDTH-1:0] in1p;
  logic [WIDTH-1:0] in2p;
  logic [2:0]       opcode;
  logic [2:0]       round_mp;
  logic             act;
  logic             done;
  logic             ov;
  logic             un;
  logic             inv;
  logic             eq;
  logic             great;
  logic             less;
  logic [WIDTH-1:0] out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_out;
  logic [6:0]       rsp_flags;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_in1, cmd_in2, cmd_op, cmd_rm,
    output cmd_ready,
    output in1p, in2p, opcode, round_mp, act,
    input  done, ov, un, inv, eq, great, less, out,
    output rsp_valid, rsp_out, rsp_flags, busy,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_in1, cmd_in2, cmd_op, cmd_rm,
    input  cmd_ready,
    input  in1p, in2p, opcode, round_mp, act,
    output done, ov, un, inv, eq, great, less, out,
    input  rsp_valid, rsp_out, rsp_flags, busy,
    output rsp_ready
  );

endinterface

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through read.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fpu_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstp,
  input  logic                 push_i,
  input  logic [2*WIDTH+5:0]   data_i,
  input  logic                 pop_i,
  output logic [2*WIDTH+5:0]   data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int DW = 2 * WIDTH + 6;
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   wr_ptr_d;
  logic [AW:0]   rd_ptr_q;
  logic [AW:0]   rd_ptr_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/fpu_cmd_seq.sv
// Sequencer feeding one queued command at a time into the FPU, waiting for
// done (with timeout) and returning the captured result on a response port.
module fpu_cmd_seq
  import fpu_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rstp,
  fpu_cmd_seq_if.slave  bus
);

  localparam int            DW        = 2 * WIDTH + 6;
  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic [WIDTH-1:0]   in1_q;
  logic [WIDTH-1:0]   in1_d;
  logic [WIDTH-1:0]   in2_q;
  logic [WIDTH-1:0]   in2_d;
  logic [2:0]         op_q;
  logic [2:0]         op_d;
  logic [2:0]         rm_q;
  logic [2:0]         rm_d;
  logic               act_q;
  logic               act_d;
  logic               rsp_valid_q;
  logic               rsp_valid_d;
  logic [WIDTH-1:0]   rsp_out_q;
  logic [WIDTH-1:0]   rsp_out_d;
  logic [FLAGS_W-1:0] rsp_flags_q;
  logic [FLAGS_W-1:0] rsp_flags_d;

  logic [DW-1:0]      push_data_s;
  logic [DW-1:0]      head_s;
  logic [WIDTH-1:0]   head_in1_s;
  logic [WIDTH-1:0]   head_in2_s;
  logic [2:0]         head_op_s;
  logic [2:0]         head_rm_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               pop_s;

  assign push_data_s = {bus.cmd_in1, bus.cmd_in2, bus.cmd_op, bus.cmd_rm};
  assign {head_in1_s, head_in2_s, head_op_s, head_rm_s} = head_s;

  fpu_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstp    (rstp),
    .push_i  (bus.cmd_valid),
    .data_i  (push_data_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Next-state, pop request, timeout counter and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop_s       = 1'b0;
    rsp_out_d   = rsp_out_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        // cnt_q == 0 marks the first RUN cycle, where done may still be
        // left over from the previous operation.
        if (bus.done && (cnt_q != '0)) begin
          rsp_out_d   = bus.out;
          rsp_flags_d = pack_flags(1'b0, bus.inv, bus.ov, bus.un,
                                   bus.eq, bus.great, bus.less);
          state_d     = RESP;
        end else if (cnt_d == CNT_LIMIT) begin
          rsp_out_d   = '0;
          rsp_flags_d = FLAGS_TIMEOUT;
          state_d     = RESP;
        end else begin
          state_d = RUN;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            state_d = ARM;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand registers load only on a pop; act/rsp_valid follow next state.
  always_comb begin
    in1_d       = in1_q;
    in2_d       = in2_q;
    op_d        = op_q;
    rm_d        = rm_q;
    act_d       = (state_d == RUN) || (state_d == RESP);
    rsp_valid_d = (state_d == RESP);
    if (pop_s) begin
      in1_d = head_in1_s;
      in2_d = head_in2_s;
      op_d  = head_op_s;
      rm_d  = head_rm_s;
    end else begin
      in1_d = in1_q;
      in2_d = in2_q;
      op_d  = op_q;
      rm_d  = rm_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      op_q        <= 3'b000;
      rm_q        <= 3'b000;
      act_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      op_q        <= op_d;
      rm_q        <= rm_d;
      act_q       <= act_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign bus.cmd_ready = !fifo_full_s;
  assign bus.in1p      = in1_q;
  assign bus.in2p      = in2_q;
  assign bus.opcode    = op_q;
  assign bus.round_mp  = rm_q;
  assign bus.act       = act_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.busy      = (state_q != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_fpu_cmd_seq.sv
// Directed plus randomized bench for fpu_cmd_seq with a behavioural FPU
// and an in-order response scoreboard.
module tb_fpu_cmd_seq;
  import fpu_seq_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int TO = 8;
  localparam logic [2:0] OP_HANG = 3'b111;

  logic clk = 1'b0;
  logic rstp;
  int   vectors     = 0;
  int   miscompares = 0;
  int   lat         = 3;
  bit   stale_mode  = 1'b0;
  bit   rand_mode   = 1'b0;
  int   f_cnt       = 0;
  bit   f_held      = 1'b0;

  typedef struct {
    logic [31:0] in1;
    logic [2:0]  op;
    logic [31:0] out;
    logic [6:0]  flags;
  } exp_t;
  exp_t sb[$];

  logic [2:0] t2_ops [5] = '{OP_MUL, OP_SUB, OP_ADD, OP_CMP, OP_DIV};

  fpu_cmd_seq_if #(.WIDTH(W)) bus ();

  fpu_cmd_seq #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstp (rstp),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // What the FPU computes: {out, inv, ov, un, eq, great, less}.
  function automatic logic [37:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    logic [31:0] o;
    o = (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
    if (a == 32'h3F8CCCCD && b == 32'hBFA66666 && op == OP_ADD) o = 32'hBE4CCCCC;
    return {o, (op == OP_DIV) && b[0], (op == OP_MUL) && a[30] && b[30],
            (op == OP_MUL) && !a[30] && !b[30] && a[0],
            (op == OP_CMP) && (a == b), (op == OP_CMP) && (a > b), (op == OP_CMP) && (a < b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      lat           = $urandom_range(1, 6);
      stale_mode    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [2:0] rm);
    int   g;
    exp_t e;
    logic [37:0] r;
    g = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_in1 = a; bus.cmd_in2 = b; bus.cmd_op = op; bus.cmd_rm = rm;
    while (!bus.cmd_ready && g < 200) begin tick(); g++; end
    if (g == 200) begin
      chk("push_wait_ready", bus.cmd_ready, 1'b1);
    end else begin
      r     = fpu_calc(a, b, op);
      e.in1 = a; e.op = op;
      e.out   = (op == OP_HANG) ? 32'h0 : r[37:6];
      e.flags = (op == OP_HANG) ? 7'b1000000 : {1'b0, r[5:0]};
      tick();
      sb.push_back(e);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!bus.rsp_valid && g < 100) begin tick(); g++; end
    if (g == 100) chk("wait_rsp_valid", bus.rsp_valid, 1'b1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    bus.rsp_ready = 1'b1;
    while ((sb.size() != 0 || bus.busy) && g < 2000) begin tick(); g++; end
    chk("drain_sb_left", sb.size(), 0);
    chk("drain_busy", bus.busy, 1'b0);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_act"}, bus.act, 1'b0);
    chk({p, "_in1p"}, bus.in1p, 32'h0);
    chk({p, "_in2p"}, bus.in2p, 32'h0);
    chk({p, "_opcode"}, bus.opcode, 3'b000);
    chk({p, "_round_mp"}, bus.round_mp, 3'b000);
    chk({p, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({p, "_rsp_out"}, bus.rsp_out, 32'h0);
    chk({p, "_rsp_flags"}, bus.rsp_flags, 7'h00);
    chk({p, "_busy"}, bus.busy, 1'b0);
    chk({p, "_cmd_ready"}, bus.cmd_ready, 1'b1);
  endtask

  // Behavioural FPU: done after lat act-high cycles; optional stale done.
  always @(posedge clk) begin
    if (rstp) begin
      f_cnt <= 0; f_held <= 1'b0; bus.done <= 1'b0; bus.out <= 32'h0;
      {bus.inv, bus.ov, bus.un, bus.eq, bus.great, bus.less} <= 6'h00;
    end else if (bus.act) begin
      f_held <= 1'b0;
      f_cnt  <= f_cnt + 1;
      if (bus.opcode != OP_HANG && f_cnt + 1 >= lat) begin
        {bus.out, bus.inv, bus.ov, bus.un, bus.eq, bus.great, bus.less}
          <= fpu_calc(bus.in1p, bus.in2p, bus.opcode);
        bus.done <= 1'b1;
      end else begin
        bus.done <= 1'b0;
      end
    end else begin
      f_cnt <= 0;
      if (stale_mode && bus.done && !f_held) f_held <= 1'b1;
      else begin bus.done <= 1'b0; f_held <= 1'b0; end
    end
  end

  // Response checker: each consumed response matches the oldest command.
  always @(negedge clk) begin
    if (!rstp && bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_out", bus.rsp_out, e.out);
        chk("rsp_flags", bus.rsp_flags, e.flags);
        chk("rsp_opcode", bus.opcode, e.op);
        chk("rsp_in1p", bus.in1p, e.in1);
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    rstp = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_in1 = 32'h0; bus.cmd_in2 = 32'h0;
    bus.cmd_op = 3'b000; bus.cmd_rm = 3'b000; bus.rsp_ready = 1'b0;
    tick(); tick(); tick();
    chk_reset("rst");
    rstp = 1'b0;
    tick();
    chk_reset("post_rst");

    // Single operation with exact latency.
    lat = 3;
    push(32'h3F8CCCCD, 32'hBFA66666, OP_ADD, 3'b001);
    chk("t1_busy", bus.busy, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t1_act", bus.act, i >= 2);
      chk("t1_rsp_valid", bus.rsp_valid, i == 6);
    end
    chk("t1_round_mp", bus.round_mp, 3'b001);
    chk("t1_rsp_out", bus.rsp_out, 32'hBE4CCCCC);
    chk("t1_flags", bus.rsp_flags, 7'h00);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("t1_idle_act", bus.act, 1'b0);
    chk("t1_idle_valid", bus.rsp_valid, 1'b0);
    chk("t1_idle_busy", bus.busy, 1'b0);

    // Five commands against a stalled response port.
    for (int i = 0; i < 5; i++) begin
      push($urandom, $urandom, t2_ops[i], 3'($urandom_range(0, 7)));
      chk("t2_cmd_ready", bus.cmd_ready, i < 4);
    end
    tick(); tick();
    chk("t2_still_full", bus.cmd_ready, 1'b0);
    wait_valid();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("t2_ready_after_pop", bus.cmd_ready, 1'b1);
    chk("t2_arm_act", bus.act, 1'b0);
    drain();

    // Held response for ten cycles, then ARM.
    lat = 2;
    push($urandom, $urandom, OP_SUB, 3'b010);
    push($urandom, $urandom, OP_MUL, 3'b011);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid", bus.rsp_valid, 1'b1);
      chk("t3_rsp_out", bus.rsp_out, sb[0].out);
      chk("t3_act", bus.act, 1'b1);
      chk("t3_in1p", bus.in1p, sb[0].in1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("t3_arm_act", bus.act, 1'b0);
    chk("t3_arm_valid", bus.rsp_valid, 1'b0);
    chk("t3_next_in1p", bus.in1p, sb[0].in1);
    tick();
    chk("t3_run_act", bus.act, 1'b1);
    drain();

    // Timeout: FPU never answers.
    push($urandom, $urandom, OP_HANG, 3'b000);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("t4_act", bus.act, i >= 2);
      chk("t4_rsp_valid", bus.rsp_valid, i == 10);
    end
    chk("t4_flags", bus.rsp_flags, 7'b1000000);
    chk("t4_out", bus.rsp_out, 32'h0);
    drain();
    push($urandom, $urandom, OP_DIV, 3'b100);
    drain();

    // Stale done left over from the previous operation.
    stale_mode = 1'b1; lat = 1;
    bus.rsp_ready = 1'b1;
    push(32'h12345678, 32'h9ABCDEF0, OP_ADD, 3'b000);
    push(32'h0F0F0F0F, 32'h7070F0F0, OP_MUL, 3'b001);
    drain();
    stale_mode = 1'b0; lat = 3;

    // Reset in the middle of RUN with two queued commands.
    push($urandom, $urandom, OP_HANG, 3'b000);
    push($urandom, $urandom, OP_ADD, 3'b000);
    push($urandom, $urandom, OP_SUB, 3'b000);
    tick();
    chk("t6_in_run", bus.act, 1'b1);
    #2;
    rstp = 1'b1;
    #1;
    chk_reset("t6_async");
    sb.delete();
    tick(); tick();
    rstp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_rsp", bus.rsp_valid, 1'b0);
      chk("t6_idle", bus.busy, 1'b0);
    end

    // Randomized traffic with random backpressure, latency and stale done.
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) tick();
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      op = ($urandom_range(0, 9) == 0) ? OP_HANG : 3'($urandom_range(0, 4));
      push(a, b, op, 3'($urandom_range(0, 7)));
    end
    rand_mode = 1'b0;
    stale_mode = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
